// File: rtl/axi_aw_arbiter_pkg.sv
// Shared types and helpers for the AW-channel round-robin arbiter.
// Contents:
//   - AW field widths, which the interface and the holding register both use.
//   - aw_payload_t : the holding-register payload (every AW field except the handshake).
//   - idx_width()  : width of a requester index, never less than 1.
package axi_aw_arbiter_pkg;

  localparam int unsigned AW_ID_W     = 1;
  localparam int unsigned AW_ADDR_W   = 32;
  localparam int unsigned AW_USER_W   = 1;
  localparam int unsigned AW_LEN_W    = 8;
  localparam int unsigned AW_SIZE_W   = 3;
  localparam int unsigned AW_BURST_W  = 2;
  localparam int unsigned AW_CACHE_W  = 4;
  localparam int unsigned AW_PROT_W   = 3;
  localparam int unsigned AW_QOS_W    = 4;
  localparam int unsigned AW_REGION_W = 4;

  typedef struct packed {
    logic [AW_ID_W-1:0]     id;
    logic [AW_ADDR_W-1:0]   addr;
    logic [AW_LEN_W-1:0]    len;
    logic [AW_SIZE_W-1:0]   size;
    logic [AW_BURST_W-1:0]  burst;
    logic                   lock;
    logic [AW_CACHE_W-1:0]  cache;
    logic [AW_PROT_W-1:0]   prot;
    logic [AW_QOS_W-1:0]    qos;
    logic [AW_REGION_W-1:0] region;
    logic [AW_USER_W-1:0]   user;
  } aw_payload_t;

  // Width of a requester index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_aw_arbiter_if.sv
// AXI write address channel bundle.
// Modports:
//   - master : drives the payload fields and awvalid, and receives awready.
//   - slave  : receives the payload fields and awvalid, and drives awready.
interface axi_write_address_channel
  import axi_aw_arbiter_pkg::*;
#(
  parameter int unsigned AXI_AWID_WIDTH   = 1,
  parameter int unsigned AXI_AWADDR_WIDTH = 32,
  parameter int unsigned AXI_AWUSER_WIDTH = 1
);
  logic [AXI_AWID_WIDTH-1:0]   awid;
  logic [AXI_AWADDR_WIDTH-1:0] awaddr;
  logic [AW_LEN_W-1:0]         awlen;
  logic [AW_SIZE_W-1:0]        awsize;
  logic [AW_BURST_W-1:0]       awburst;
  logic                        awlock;
  logic [AW_CACHE_W-1:0]       awcache;
  logic [AW_PROT_W-1:0]        awprot;
  logic [AW_QOS_W-1:0]         awqos;
  logic [AW_REGION_W-1:0]      awregion;
  logic [AXI_AWUSER_WIDTH-1:0] awuser;
  logic                        awvalid;
  logic                        awready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache,
           awprot, awqos, awregion, awuser, awvalid,
    input  awready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache,
           awprot, awqos, awregion, awuser, awvalid,
    output awready
  );
endinterface

// File: rtl/axi_aw_arbiter_order_fifo.sv
// Synchronous FIFO that holds the order of granted requester indices.
// The head is not bypassed: a pushed entry becomes visible the cycle after the push.
// Ports:
//   clk, rst  : clock, and asynchronous active-high reset.
//   push      : write push_data. It is ignored when the FIFO is full.
//   push_data : value to store.
//   pop       : drop the head entry. It is ignored when the FIFO is empty.
//   head      : entry at the head of the FIFO.
//   valid     : FIFO holds at least one entry.
//   count     : current occupancy.
module axi_aw_arbiter_order_fifo #(
  parameter  int unsigned DEPTH = 8,
  parameter  int unsigned WIDTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             valid_q;
  logic             push_ok_c;
  logic             pop_ok_c;

  assign push_ok_c = push && (count_q != CNT_W'(DEPTH));
  assign pop_ok_c  = pop && valid_q;

  // Occupancy update. A push and a pop in the same cycle cancel out.
  always_comb begin
    count_d = count_q;
    case ({push_ok_c, pop_ok_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage and pointers. DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (push_ok_c) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      valid_q <= (count_d != '0);
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign valid = valid_q;
  assign count = count_q;

endmodule

// File: rtl/axi_aw_arbiter.sv
// Round-robin arbiter that shares one AXI AW channel among NREQ requesters.
// Each winning beat goes into a registered holding stage that drives m_aw. The winner's
// index is pushed into an order FIFO, which the W-channel mux pops to route write data
// in the same order.
// Optional feature: define AXI_AW_ARBITER_QOS_EN to restrict arbitration to the valid
// requesters that present the highest awqos.
// Ports:
//   clk, rst    : clock, and asynchronous active-high reset.
//   s_aw[NREQ]  : requester AW channels (slave side). awready is combinational.
//   m_aw        : shared AW channel toward the interconnect (master side, registered).
//   order_idx   : requester index at the head of the order FIFO.
//   order_valid : order FIFO is not empty.
//   order_ready : pop request from the W mux.
//   order_count : order FIFO occupancy.
module axi_aw_arbiter
  import axi_aw_arbiter_pkg::*;
#(
  parameter  int unsigned NREQ             = 4,
  parameter  int unsigned AXI_AWID_WIDTH   = 1,
  parameter  int unsigned AXI_AWADDR_WIDTH = 32,
  parameter  int unsigned AXI_AWUSER_WIDTH = 1,
  parameter  int unsigned ORDER_DEPTH      = 8,
  localparam int unsigned IDX_W            = idx_width(NREQ),
  localparam int unsigned CNT_W            = $clog2(ORDER_DEPTH + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  axi_write_address_channel.slave         s_aw [NREQ],
  axi_write_address_channel.master        m_aw,
  output logic [IDX_W-1:0]                order_idx,
  output logic                            order_valid,
  input  logic                            order_ready,
  output logic [CNT_W-1:0]                order_count
);

  aw_payload_t      req_payload [NREQ];
  logic [NREQ-1:0]  req_valid;
  logic [NREQ-1:0]  cand_c;
  logic [NREQ-1:0]  grant_c;
  logic [IDX_W-1:0] winner_c;
  logic [IDX_W-1:0] probe_c;
  logic             found_c;
  logic             free_c;
  logic             capture_c;

  aw_payload_t      hold_q;
  logic             hold_valid_q;
  logic [IDX_W-1:0] last_q;

  // Gather the requester ports into arrays that procedural code can index.
  // The id/addr/user casts adapt the port widths to the payload struct.
  for (genvar i = 0; i < NREQ; i++) begin : g_req
    assign req_valid[i]   = s_aw[i].awvalid;
    assign req_payload[i] = '{
      id:     AW_ID_W'(s_aw[i].awid),
      addr:   AW_ADDR_W'(s_aw[i].awaddr),
      len:    s_aw[i].awlen,
      size:   s_aw[i].awsize,
      burst:  s_aw[i].awburst,
      lock:   s_aw[i].awlock,
      cache:  s_aw[i].awcache,
      prot:   s_aw[i].awprot,
      qos:    s_aw[i].awqos,
      region: s_aw[i].awregion,
      user:   AW_USER_W'(s_aw[i].awuser)
    };
    assign s_aw[i].awready = grant_c[i];
  end

  // The holding stage is free when it is empty, or when it is being drained this cycle.
  // A pop in the same cycle does not relieve a full FIFO, because the registered count is used.
  assign free_c    = !hold_valid_q || m_aw.awready;
  assign capture_c = !rst && free_c && (|req_valid) && (order_count != CNT_W'(ORDER_DEPTH));

`ifdef AXI_AW_ARBITER_QOS_EN
  logic [AW_QOS_W-1:0] max_qos_c;

  // Candidates are the valid requesters that present the highest QoS.
  always_comb begin
    max_qos_c = '0;
    cand_c    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req_valid[i] && (req_payload[i].qos > max_qos_c)) max_qos_c = req_payload[i].qos;
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand_c[i] = req_valid[i] && (req_payload[i].qos == max_qos_c);
    end
  end
`else
  // Every valid requester is a candidate. QoS is only forwarded.
  always_comb begin
    cand_c = req_valid;
  end
`endif

  // Round-robin search that starts at last+1 (modulo NREQ). The first candidate found wins.
  always_comb begin
    winner_c = last_q;
    probe_c  = last_q;
    found_c  = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      probe_c = IDX_W'((32'(last_q) + k) % NREQ);
      if (!found_c && cand_c[probe_c]) begin
        winner_c = probe_c;
        found_c  = 1'b1;
      end
    end
  end

  // Only the winner sees awready, and only in the capture cycle.
  always_comb begin
    grant_c = '0;
    if (capture_c) grant_c[winner_c] = 1'b1;
  end

  // Holding register and round-robin pointer. The payload is held steady while a beat stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      last_q       <= IDX_W'(NREQ - 1);
    end else if (capture_c) begin
      hold_q       <= req_payload[winner_c];
      hold_valid_q <= 1'b1;
      last_q       <= winner_c;
    end else if (m_aw.awready) begin
      hold_valid_q <= 1'b0;
    end
  end

  assign m_aw.awvalid  = hold_valid_q;
  assign m_aw.awid     = AXI_AWID_WIDTH'(hold_q.id);
  assign m_aw.awaddr   = AXI_AWADDR_WIDTH'(hold_q.addr);
  assign m_aw.awlen    = hold_q.len;
  assign m_aw.awsize   = hold_q.size;
  assign m_aw.awburst  = hold_q.burst;
  assign m_aw.awlock   = hold_q.lock;
  assign m_aw.awcache  = hold_q.cache;
  assign m_aw.awprot   = hold_q.prot;
  assign m_aw.awqos    = hold_q.qos;
  assign m_aw.awregion = hold_q.region;
  assign m_aw.awuser   = AXI_AWUSER_WIDTH'(hold_q.user);

  // Grant-order FIFO that the W mux consumes.
  axi_aw_arbiter_order_fifo #(
    .DEPTH (ORDER_DEPTH),
    .WIDTH (IDX_W)
  ) u_order_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (capture_c),
    .push_data (winner_c),
    .pop       (order_valid && order_ready),
    .head      (order_idx),
    .valid     (order_valid),
    .count     (order_count)
  );

endmodule

// File: tb/tb_axi_aw_arbiter.sv
// Self-checking bench for axi_aw_arbiter (NREQ=4, ORDER_DEPTH=8).
// Expected m_aw beats and expected order-FIFO pops are queued by each scenario. A negedge
// monitor pops and compares them against what the DUT produces.
module tb_axi_aw_arbiter;
  import axi_aw_arbiter_pkg::*;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0] v = '0;
  logic [NREQ-1:0] idv = 4'b1010;
  logic [31:0]     a [NREQ];
  logic [7:0]      l [NREQ];
  logic [3:0]      q [NREQ];
  bit              sticky [NREQ];
  logic            mready = 1'b0;
  logic            oready = 1'b0;
  logic [NREQ-1:0] s_ready;
  logic [1:0]      order_idx;
  logic            order_valid;
  logic [3:0]      order_count;

  axi_write_address_channel s_aw [NREQ] ();
  axi_write_address_channel m_aw ();

  for (genvar i = 0; i < NREQ; i++) begin : g_drv
    assign s_aw[i].awvalid  = v[i];
    assign s_aw[i].awid     = idv[i];
    assign s_aw[i].awaddr   = a[i];
    assign s_aw[i].awlen    = l[i];
    assign s_aw[i].awsize   = 3'd2;
    assign s_aw[i].awburst  = 2'b01;
    assign s_aw[i].awlock   = 1'b0;
    assign s_aw[i].awcache  = 4'h3;
    assign s_aw[i].awprot   = 3'd0;
    assign s_aw[i].awqos    = q[i];
    assign s_aw[i].awregion = 4'd0;
    assign s_aw[i].awuser   = 1'b0;
    assign s_ready[i]       = s_aw[i].awready;
  end
  assign m_aw.awready = mready;

  axi_aw_arbiter #(
    .NREQ             (NREQ),
    .AXI_AWID_WIDTH   (1),
    .AXI_AWADDR_WIDTH (32),
    .AXI_AWUSER_WIDTH (1),
    .ORDER_DEPTH      (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_aw        (s_aw),
    .m_aw        (m_aw),
    .order_idx   (order_idx),
    .order_valid (order_valid),
    .order_ready (oready),
    .order_count (order_count)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic        id;
  } beat_t;

  beat_t exp_q [$];
  int    ord_q [$];
  int    grants [$];
  int    n_tests = 0;
  int    n_fail  = 0;

  // Scoreboard: m_aw handshakes and order-FIFO pops are compared on the falling edge.
  always @(negedge clk) begin : mon
    beat_t e;
    int    oi;
    if (!rst) begin
      if (m_aw.awvalid && m_aw.awready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL m_aw_unexpected got addr=%h, no beat expected", m_aw.awaddr);
        end else begin
          e = exp_q.pop_front();
          if (m_aw.awaddr !== e.addr || m_aw.awlen !== e.len || m_aw.awid !== e.id) begin
            n_fail++;
            $display("FAIL m_aw_beat got addr=%h len=%0d id=%0d expected addr=%h len=%0d id=%0d",
                     m_aw.awaddr, m_aw.awlen, m_aw.awid, e.addr, e.len, e.id);
          end
        end
      end
      if (order_valid && oready) begin
        n_tests++;
        if (ord_q.size() == 0) begin
          n_fail++;
          $display("FAIL order_unexpected got idx=%0d, no pop expected", order_idx);
        end else begin
          oi = ord_q.pop_front();
          if (order_idx !== 2'(oi)) begin
            n_fail++;
            $display("FAIL order_idx got %0d expected %0d", order_idx, oi);
          end
        end
      end
    end
  end

  // Advance one cycle. Requester handshakes are sampled on the falling edge, and the
  // requester side reacts after the rising edge.
  task automatic step();
    logic [NREQ-1:0] hs;
    @(negedge clk);
    hs = v & s_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (hs[i]) begin
        grants.push_back(i);
        if (sticky[i]) a[i] = a[i] + 32'd1;
        else v[i] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    v      = '0;
    mready = 1'b0;
    oready = 1'b0;
    idv    = 4'b1010;
    for (int i = 0; i < NREQ; i++) begin
      a[i] = '0; l[i] = '0; q[i] = '0; sticky[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    ord_q.delete();
    grants.delete();
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    v = '1;
    mready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (m_aw.awvalid !== 1'b0) begin n_fail++; $display("FAIL rst_awvalid got %b expected 0", m_aw.awvalid); end
    n_tests++; if (m_aw.awaddr !== 32'd0) begin n_fail++; $display("FAIL rst_awaddr got %h expected 0", m_aw.awaddr); end
    n_tests++; if (s_ready !== 4'b0) begin n_fail++; $display("FAIL rst_s_awready got %b expected 0000", s_ready); end
    n_tests++; if (order_valid !== 1'b0) begin n_fail++; $display("FAIL rst_order_valid got %b expected 0", order_valid); end
    n_tests++; if (order_idx !== 2'd0) begin n_fail++; $display("FAIL rst_order_idx got %0d expected 0", order_idx); end
    n_tests++; if (order_count !== 4'd0) begin n_fail++; $display("FAIL rst_order_count got %0d expected 0", order_count); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    mready = 1'b1;
    a[2] = 32'h1000; l[2] = 8'd3; v[2] = 1'b1;
    exp_q.push_back('{addr: 32'h1000, len: 8'd3, id: idv[2]});
    step();
    n_tests++; if (grants.size() != 1 || grants[0] != 2) begin n_fail++; $display("FAIL single_grant got n=%0d expected one grant to 2", grants.size()); end
    n_tests++; if (m_aw.awvalid !== 1'b1 || m_aw.awaddr !== 32'h1000 || m_aw.awlen !== 8'd3) begin
      n_fail++; $display("FAIL single_m_aw got v=%b addr=%h len=%0d expected 1/1000/3", m_aw.awvalid, m_aw.awaddr, m_aw.awlen); end
    n_tests++; if (order_idx !== 2'd2 || order_count !== 4'd1 || order_valid !== 1'b1) begin
      n_fail++; $display("FAIL single_order got idx=%0d cnt=%0d v=%b expected 2/1/1", order_idx, order_count, order_valid); end
    step();
    n_tests++; if (m_aw.awvalid !== 1'b0) begin n_fail++; $display("FAIL single_drain got awvalid=%b expected 0", m_aw.awvalid); end
    oready = 1'b1; ord_q.push_back(2);
    step();
    oready = 1'b0;
    n_tests++; if (order_count !== 4'd0 || exp_q.size() != 0 || ord_q.size() != 0) begin
      n_fail++; $display("FAIL single_end got cnt=%0d exp_left=%0d ord_left=%0d expected 0/0/0", order_count, exp_q.size(), ord_q.size()); end
  endtask

  task automatic test_round_robin();
    int bad;
    do_reset();
    mready = 1'b1; oready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      sticky[i] = 1'b1; a[i] = 32'h0001_0000 * (i + 1); l[i] = 8'(i);
    end
    for (int k = 0; k < 12; k++) begin
      exp_q.push_back('{addr: 32'h0001_0000 * ((k % 4) + 1) + 32'(k / 4), len: 8'(k % 4), id: idv[k % 4]});
      ord_q.push_back(k % 4);
    end
    v = '1;
    repeat (12) step();
    v = '0;
    repeat (3) step();
    bad = 0;
    for (int k = 0; k < grants.size(); k++) if (grants[k] != k % 4) bad++;
    n_tests++; if (grants.size() != 12 || bad != 0) begin n_fail++; $display("FAIL rr_order got n=%0d wrong=%0d expected 12 grants 0,1,2,3,...", grants.size(), bad); end
    n_tests++; if (exp_q.size() != 0 || ord_q.size() != 0 || order_count !== 4'd0) begin
      n_fail++; $display("FAIL rr_drain got exp_left=%0d ord_left=%0d cnt=%0d expected 0/0/0", exp_q.size(), ord_q.size(), order_count); end
  endtask

  task automatic test_backpressure();
    do_reset();
    a[1] = 32'h2000; l[1] = 8'd7; v[1] = 1'b1;
    step();
    v[1] = 1'b1; a[1] = 32'h2001;
    for (int c = 0; c < 5; c++) begin
      step();
      n_tests++; if (m_aw.awvalid !== 1'b1 || m_aw.awaddr !== 32'h2000 || m_aw.awlen !== 8'd7) begin
        n_fail++; $display("FAIL bp_stable cycle %0d got v=%b addr=%h len=%0d expected 1/2000/7", c, m_aw.awvalid, m_aw.awaddr, m_aw.awlen); end
    end
    n_tests++; if (grants.size() != 1 || order_count !== 4'd1) begin
      n_fail++; $display("FAIL bp_hold got grants=%0d cnt=%0d expected 1/1", grants.size(), order_count); end
    exp_q.push_back('{addr: 32'h2000, len: 8'd7, id: idv[1]});
    exp_q.push_back('{addr: 32'h2001, len: 8'd7, id: idv[1]});
    mready = 1'b1;
    step();
    n_tests++; if (grants.size() != 2 || m_aw.awaddr !== 32'h2001) begin
      n_fail++; $display("FAIL bp_release got grants=%0d addr=%h expected 2/2001", grants.size(), m_aw.awaddr); end
    step();
    n_tests++; if (exp_q.size() != 0 || m_aw.awvalid !== 1'b0) begin
      n_fail++; $display("FAIL bp_end got exp_left=%0d awvalid=%b expected 0/0", exp_q.size(), m_aw.awvalid); end
  endtask

  task automatic test_fifo_full();
    do_reset();
    mready = 1'b1;
    sticky[0] = 1'b1; a[0] = 32'h3000; l[0] = 8'd1; v[0] = 1'b1;
    for (int k = 0; k < 9; k++) exp_q.push_back('{addr: 32'h3000 + 32'(k), len: 8'd1, id: idv[0]});
    repeat (11) step();
    n_tests++; if (grants.size() != 8 || order_count !== 4'd8 || m_aw.awvalid !== 1'b0) begin
      n_fail++; $display("FAIL full_stop got grants=%0d cnt=%0d awvalid=%b expected 8/8/0", grants.size(), order_count, m_aw.awvalid); end
    oready = 1'b1; ord_q.push_back(0);
    step();
    oready = 1'b0;
    n_tests++; if (grants.size() != 8 || order_count !== 4'd7) begin
      n_fail++; $display("FAIL full_pop_cycle got grants=%0d cnt=%0d expected 8/7", grants.size(), order_count); end
    step();
    v[0] = 1'b0;
    n_tests++; if (grants.size() != 9 || order_count !== 4'd8) begin
      n_fail++; $display("FAIL full_ninth got grants=%0d cnt=%0d expected 9/8", grants.size(), order_count); end
    step();
    n_tests++; if (exp_q.size() != 0 || ord_q.size() != 0) begin
      n_fail++; $display("FAIL full_end got exp_left=%0d ord_left=%0d expected 0/0", exp_q.size(), ord_q.size()); end
  endtask

  task automatic test_qos();
    int w [6];
    int n1;
    int n3;
    int bad;
    do_reset();
    mready = 1'b1; oready = 1'b1;
    sticky[1] = 1'b1; sticky[3] = 1'b1;
    q[1] = 4'd2; q[3] = 4'd7;
    a[1] = 32'h4100; a[3] = 32'h4300;
    n1 = 0; n3 = 0;
    for (int k = 0; k < 6; k++) begin
`ifdef AXI_AW_ARBITER_QOS_EN
      w[k] = 3;
`else
      w[k] = (k % 2 == 0) ? 1 : 3;
`endif
      if (w[k] == 1) begin exp_q.push_back('{addr: 32'h4100 + 32'(n1), len: 8'd0, id: idv[1]}); n1++; end
      else begin exp_q.push_back('{addr: 32'h4300 + 32'(n3), len: 8'd0, id: idv[3]}); n3++; end
      ord_q.push_back(w[k]);
    end
    v[1] = 1'b1; v[3] = 1'b1;
    repeat (6) step();
    v = '0;
    repeat (2) step();
    bad = 0;
    for (int k = 0; k < grants.size() && k < 6; k++) if (grants[k] != w[k]) bad++;
    n_tests++; if (grants.size() != 6 || bad != 0) begin n_fail++; $display("FAIL qos_order got n=%0d wrong=%0d expected 6 grants", grants.size(), bad); end
    n_tests++; if (exp_q.size() != 0 || ord_q.size() != 0) begin
      n_fail++; $display("FAIL qos_drain got exp_left=%0d ord_left=%0d expected 0/0", exp_q.size(), ord_q.size()); end
  endtask

  task automatic test_reset_mid();
    int bad;
    do_reset();
    mready = 1'b1;
    a[0] = 32'h5000; a[1] = 32'h5100; a[2] = 32'h5200;
    v = 4'b0111;
    exp_q.push_back('{addr: 32'h5000, len: 8'd0, id: idv[0]});
    exp_q.push_back('{addr: 32'h5100, len: 8'd0, id: idv[1]});
    repeat (3) step();
    mready = 1'b0;
    n_tests++; if (m_aw.awvalid !== 1'b1 || m_aw.awaddr !== 32'h5200 || order_count !== 4'd3) begin
      n_fail++; $display("FAIL mid_setup got v=%b addr=%h cnt=%0d expected 1/5200/3", m_aw.awvalid, m_aw.awaddr, order_count); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (m_aw.awvalid !== 1'b0 || m_aw.awaddr !== 32'd0) begin
      n_fail++; $display("FAIL mid_async_aw got v=%b addr=%h expected 0/0", m_aw.awvalid, m_aw.awaddr); end
    n_tests++; if (order_count !== 4'd0 || order_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_async_fifo got cnt=%0d v=%b expected 0/0", order_count, order_valid); end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL mid_pre_delivered got exp_left=%0d expected 0", exp_q.size()); end
    do_reset();
    mready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      a[i] = 32'h6000 + 32'h100 * i;
      exp_q.push_back('{addr: 32'h6000 + 32'h100 * i, len: 8'd0, id: idv[i]});
    end
    v = '1;
    step();
    n_tests++; if (grants.size() != 1 || grants[0] != 0) begin n_fail++; $display("FAIL mid_first_grant got n=%0d expected requester 0", grants.size()); end
    repeat (5) step();
    bad = 0;
    for (int k = 0; k < grants.size(); k++) if (grants[k] != k) bad++;
    n_tests++; if (grants.size() != 4 || bad != 0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL mid_post got n=%0d wrong=%0d exp_left=%0d expected 4/0/0", grants.size(), bad, exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_fifo_full();
    test_qos();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_aw_arbiter.md
# axi_aw_arbiter

Round-robin arbiter that shares one AXI write address channel between `NREQ` requesters. It accepts AW beats from requester-side slave ports, forwards one at a time through a registered master-side output, and records the order of granted requesters in a small FIFO. The downstream W-channel mux pops that FIFO to route write data in the same order. It sits between DMA/stream engines in `sp/` and the shared AXI interconnect port.

## Interface

Parameters:
- `NREQ`, 4: number of requesters, 2..16.
- `AXI_AWID_WIDTH`, 1: AW ID width, identical on all ports.
- `AXI_AWADDR_WIDTH`, 32: AW address width.
- `AXI_AWUSER_WIDTH`, 1: AW user width.
- `ORDER_DEPTH`, 8: order FIFO entries, power of two, at least 2.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `s_aw[NREQ]`  `axi_write_address_channel.slave`  -  requester AW channels.
- `m_aw`  `axi_write_address_channel.master`  -  shared AW channel toward the interconnect.
- `order_idx`  out  `IDX_W`  requester index at the FIFO head.
- `order_valid`  out  1  FIFO not empty.
- `order_ready`  in  1  pop request from the W mux.
- `order_count`  out  `$clog2(ORDER_DEPTH+1)`  current FIFO occupancy.

## Operation

- Output holding register: all `m_aw` payload fields plus `m_aw.awvalid`.
- The holding register is free when `!m_aw.awvalid` or when `m_aw.awvalid && m_aw.awready` in the current cycle.
- Capture condition: the holding register is free, at least one `s_aw[i].awvalid` is set, and `order_count < ORDER_DEPTH`.
- A pop in the same cycle does not relieve a full FIFO.
- On capture, winner `g` is chosen round-robin. The search starts at `last+1` modulo `NREQ`, and the first valid requester wins.
- `s_aw[g].awready` = 1 combinationally in the capture cycle. All other `awready` signals are 0.
- The payload of `g` loads into the holding register, `m_aw.awvalid` becomes 1 next cycle, `g` is pushed into the order FIFO, and `last` <= `g`.
- Payload passes through unmodified, including `awid`.
- Payload and `awvalid` stay stable while `m_aw.awvalid && !m_aw.awready`, per AXI.
- `s_aw[i].awready` never depends on `s_aw[i].awvalid` of the same port except through arbitration. No requester waits more than `NREQ-1` grants.
- FIFO: pop when `order_valid && order_ready`. Push and pop in the same cycle leave the count unchanged. Pointers wrap modulo `ORDER_DEPTH`.
- Reset values:
  - `m_aw.awvalid`=0 and all `m_aw` payload=0.
  - All `s_aw[i].awready`=0.
  - `order_valid`=0, `order_idx`=0, `order_count`=0.
  - `last`=`NREQ-1`, so requester 0 wins first.
- Reset asserted mid-transaction drops `m_aw.awvalid` immediately and discards FIFO contents. Surrounding logic is reset together with this block.

## Timing

- Latency: `s_aw` handshake in cycle N, `m_aw.awvalid` high in cycle N+1.
- Throughput: one AW per cycle when `m_aw.awready` is held high. A new capture occurs in the same cycle as the `m_aw` handshake.
- `order_valid` rises the cycle after a push (first-word visible at N+1). It may precede the corresponding `m_aw` handshake.
- Combinational path: `m_aw.awready`, `s_aw[*].awvalid` and `order_count` drive `s_aw[*].awready`. No path from `order_ready` to `s_aw[*].awready`.

## Configuration

- `AXI_AW_ARBITER_QOS_EN` defined: the arbitration candidate set is reduced to valid requesters whose `awqos` equals the maximum `awqos` among valid requesters. Round-robin from `last+1` then applies within that set. Starvation of low-QoS requesters is permitted.
- Undefined: `awqos` is ignored for arbitration and only forwarded.

## Structure

- Package `axi_aw_arbiter_pkg`:
  - `localparam`-derived helper `IDX_W = (NREQ>1) ? $clog2(NREQ) : 1`, supplied as a function.
  - `typedef` for the holding-register payload struct (id, addr, len, size, burst, lock, cache, prot, qos, region, user).
- Sub-module `axi_aw_arbiter_order_fifo`: parameterised sync FIFO with push, pop, count and head output, and no bypass. Arbiter logic (winner select, `last` pointer, holding register) stays in the top module.

## Test plan

- Single requester: `s_aw[2]` sends addr 0x1000, len 3, and `m_aw.awready`=1. Expected: `m_aw` shows 0x1000/len 3 one cycle later, `order_idx`=2, `order_count`=1.
- All four requesters valid continuously with `awready`=1. Expected: grant order 0,1,2,3,0,1,… with one `m_aw` handshake per cycle.
- `m_aw.awready`=0 for 5 cycles while valid. Expected: payload stable, no `s_aw` `awready`, and exactly one FIFO entry.
- `order_ready`=0 and 9 requests with `ORDER_DEPTH`=8. Expected: captures stop at count 8. The ninth is accepted only the cycle after one pop.
- `AXI_AW_ARBITER_QOS_EN`: requester 1 has qos 2 and requester 3 has qos 7, both valid. Expected: requester 3 wins repeatedly. Without the macro, the winners alternate 1 and 3.
- `rst` asserted while `m_aw.awvalid`=1 with 3 FIFO entries. Expected: `awvalid`=0 and `order_count`=0 asynchronously, and the first post-reset grant goes to requester 0.
